// File: rtl/rv64_pkg.sv
// rtl/rv64_pkg.sv - shared RV64I opcodes, field enums and immediate decoding
package rv64_pkg;

    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // S/B/J are decoded here so later stages share one definition.
    function automatic logic [XLEN-1:0] imm_decode(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [XLEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic alu_op_e funct3_to_alu(input funct3_e f3);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv64_regfile.sv
// rtl/rv64_regfile.sv - 32x64 integer register file, 2 read + debug read, 1 write
module rv64_regfile
    import rv64_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [XLEN-1:0]   rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_b,
    input  logic              wen,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents; a same-cycle write is not forwarded.
    assign rdata_a   = (raddr_a   == '0) ? '0 : regs[raddr_a];
    assign rdata_b   = (raddr_b   == '0) ? '0 : regs[raddr_b];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

endmodule

// File: rtl/rv64_int_exec_unit.sv
// rtl/rv64_int_exec_unit.sv - single-cycle RV64I integer execute slice with writeback
module rv64_int_exec_unit
    import rv64_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   wb_result,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_en,
    output logic              illegal,
    output logic              halt,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata
);

    logic [6:0]        opcode;
    logic [6:0]        funct7;
    funct3_e           funct3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;

    alu_op_e           alu_op;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              is_word;
    logic              writes_rd;
    logic [XLEN-1:0]   res64;
    logic [31:0]       res32;
    logic [5:0]        sh64;
    logic [4:0]        sh32;

    assign opcode = inst[6:0];
    assign funct7 = inst[31:25];
    assign funct3 = funct3_e'(inst[14:12]);
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign wb_rd  = inst[11:7];
    assign imm_i  = imm_decode(inst, IMM_I);
    assign imm_u  = imm_decode(inst, IMM_U);

    rv64_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .raddr_a   (rs1),
        .rdata_a   (rs1_data),
        .raddr_b   (rs2),
        .rdata_b   (rs2_data),
        .wen       (wb_en),
        .waddr     (wb_rd),
        .wdata     (wb_result),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    always_comb begin
        alu_op    = ALU_ADD;
        op_a      = rs1_data;
        op_b      = imm_i;
        is_word   = 1'b0;
        writes_rd = 1'b1;
        illegal   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_op = ALU_PASS_B;
                op_b   = imm_u;
            end
            OPC_AUIPC: begin
                op_a = pc;
                op_b = imm_u;
            end
            OPC_OP_IMM: begin
                alu_op = funct3_to_alu(funct3);
                // inst[25] is shamt[5] for 64-bit shifts; only inst[30] selects SRAI
                if (funct3 == F3_SLL) begin
                    illegal = (inst[31:26] != 6'b0);
                end else if (funct3 == F3_SR) begin
                    alu_op  = inst[30] ? ALU_SRA : ALU_SRL;
                    illegal = ({inst[31], inst[29:26]} != 5'b0);
                end
            end
            OPC_OP: begin
                op_b   = rs2_data;
                alu_op = funct3_to_alu(funct3);
                if (inst[30] && funct3 == F3_ADD) alu_op = ALU_SUB;
                if (inst[30] && funct3 == F3_SR)  alu_op = ALU_SRA;
                illegal = ((funct7 != 7'b0000000) && (funct7 != 7'b0100000)) ||
                          (inst[30] && (funct3 != F3_ADD) && (funct3 != F3_SR));
            end
            OPC_OP_IMM_32, OPC_OP_32: begin
                is_word = 1'b1;
                if (opcode == OPC_OP_32) op_b = rs2_data;
                case (funct3)
                    F3_ADD: begin
                        if (opcode == OPC_OP_32) begin
                            alu_op  = inst[30] ? ALU_SUB : ALU_ADD;
                            illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                        end
                    end
                    F3_SLL: begin
                        alu_op  = ALU_SLL;
                        illegal = (funct7 != 7'b0000000);
                    end
                    F3_SR: begin
                        alu_op  = inst[30] ? ALU_SRA : ALU_SRL;
                        illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) writes_rd = 1'b0;
    end

    assign sh64 = op_b[5:0];
    assign sh32 = op_b[4:0];

    always_comb begin
        res64 = '0;
        res32 = '0;
        case (alu_op)
            ALU_ADD:    res64 = op_a + op_b;
            ALU_SUB:    res64 = op_a - op_b;
            ALU_SLL:    res64 = op_a << sh64;
            ALU_SLT:    res64 = {63'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   res64 = {63'b0, op_a < op_b};
            ALU_XOR:    res64 = op_a ^ op_b;
            ALU_SRL:    res64 = op_a >> sh64;
            ALU_SRA:    res64 = $unsigned($signed(op_a) >>> sh64);
            ALU_OR:     res64 = op_a | op_b;
            ALU_AND:    res64 = op_a & op_b;
            ALU_PASS_B: res64 = op_b;
            default:    res64 = '0;
        endcase
        case (alu_op)
            ALU_ADD: res32 = op_a[31:0] + op_b[31:0];
            ALU_SUB: res32 = op_a[31:0] - op_b[31:0];
            ALU_SLL: res32 = op_a[31:0] << sh32;
            ALU_SRL: res32 = op_a[31:0] >> sh32;
            ALU_SRA: res32 = $unsigned($signed(op_a[31:0]) >>> sh32);
            default: res32 = '0;
        endcase
    end

    assign wb_result = illegal ? '0 : (is_word ? {{32{res32[31]}}, res32} : res64);
    assign wb_en     = inst_valid && writes_rd && (wb_rd != '0);
    assign halt      = inst_valid && (inst == 32'h0);

endmodule

// File: tb/tb_rv64_int_exec_unit.sv
// tb/tb_rv64_int_exec_unit.sv - directed scoreboard bench for rv64_int_exec_unit
module tb_rv64_int_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        illegal;
    logic        halt;
    logic [4:0]  dbg_raddr;
    logic [63:0] dbg_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [4:0]  addr;
        logic [63:0] val;
    } sb_t;

    sb_t exp_q[$];

    always #5 clk = ~clk;

    rv64_int_exec_unit dut (
        .clk        (clk),
        .reset      (reset),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .wb_result  (wb_result),
        .wb_rd      (wb_rd),
        .wb_en      (wb_en),
        .illegal    (illegal),
        .halt       (halt),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [4:0] addr, input logic [63:0] val);
        sb_t e;
        e.tag  = tag;
        e.addr = addr;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            dbg_raddr = e.addr;
            #1;
            chk(e.tag, dbg_rdata, e.val);
        end
    endtask

    // Drive one valid instruction, check its combinational writeback, queue the
    // expected register contents and compare them once the edge has passed.
    task automatic step(input string tag, input logic [31:0] i, input logic [63:0] p,
                        input logic exp_en, input logic [63:0] exp_res,
                        input logic [4:0] chk_rd, input logic [63:0] chk_val);
        @(negedge clk);
        inst = i;
        pc = p;
        inst_valid = 1'b1;
        push({tag, "_reg"}, chk_rd, chk_val);
        #1;
        chk({tag, "_en"}, {63'b0, wb_en}, {63'b0, exp_en});
        chk({tag, "_res"}, wb_result, exp_res);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        drain();
    endtask

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_I32 = 7'b0011011;
    localparam logic [6:0] OP_32  = 7'b0111011;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        reset = 1'b1;
        inst_valid = 1'b0;
        inst = 32'h0;
        pc = 64'h0;
        dbg_raddr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push("rst_x1", 5'd1, 64'd0);
        push("rst_x31", 5'd31, 64'd0);
        drain();

        step("addi_m1", 32'hFFF00093, 64'h0, 1'b1, ONES, 5'd1, ONES);
        step("addi_x1_5", enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_IMM), 64'h0, 1'b1, 64'd5, 5'd1, 64'd5);
        step("addi_x2_7", enc_i(12'd7, 5'd0, 3'b000, 5'd2, OP_IMM), 64'h0, 1'b1, 64'd7, 5'd2, 64'd7);
        step("sub", enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, OP), 64'h0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        step("sltu", enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd4, OP), 64'h0, 1'b1, 64'd1, 5'd4, 64'd1);
        step("slt_neg", enc_r(7'b0, 5'd1, 5'd3, 3'b010, 5'd10, OP), 64'h0, 1'b1, 64'd1, 5'd10, 64'd1);

        // Same-cycle debug read of x2 while it is being written returns the old value.
        @(negedge clk);
        inst = enc_i(12'd1, 5'd2, 3'b000, 5'd2, OP_IMM);
        inst_valid = 1'b1;
        dbg_raddr = 5'd2;
        #1;
        chk("no_bypass", dbg_rdata, 64'd7);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        push("x2_after", 5'd2, 64'd8);
        drain();

        step("addi_x1_1", enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_IMM), 64'h0, 1'b1, 64'd1, 5'd1, 64'd1);
        step("slli63", enc_i(12'd63, 5'd1, 3'b001, 5'd1, OP_IMM), 64'h0, 1'b1,
             64'h8000_0000_0000_0000, 5'd1, 64'h8000_0000_0000_0000);
        step("srai63", enc_i(12'h43F, 5'd1, 3'b101, 5'd5, OP_IMM), 64'h0, 1'b1, ONES, 5'd5, ONES);
        step("srli63", enc_i(12'h03F, 5'd1, 3'b101, 5'd9, OP_IMM), 64'h0, 1'b1, 64'd1, 5'd9, 64'd1);
        step("subw", enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd11, OP_32), 64'h0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFF8, 5'd11, 64'hFFFF_FFFF_FFFF_FFF8);

        step("lui", enc_u(20'h7FFFF, 5'd6, 7'b0110111), 64'h0, 1'b1, 64'h7FFF_F000, 5'd6, 64'h7FFF_F000);
        step("addiw_a", enc_i(12'h7FF, 5'd6, 3'b000, 5'd6, OP_I32), 64'h0, 1'b1, 64'h7FFF_F7FF, 5'd6, 64'h7FFF_F7FF);
        step("addiw_b", enc_i(12'h7FF, 5'd6, 3'b000, 5'd6, OP_I32), 64'h0, 1'b1, 64'h7FFF_FFFE, 5'd6, 64'h7FFF_FFFE);
        step("addiw_c", enc_i(12'd1, 5'd6, 3'b000, 5'd6, OP_I32), 64'h0, 1'b1, 64'h7FFF_FFFF, 5'd6, 64'h7FFF_FFFF);
        step("addiw_ovf", enc_i(12'd1, 5'd6, 3'b000, 5'd7, OP_I32), 64'h0, 1'b1,
             64'hFFFF_FFFF_8000_0000, 5'd7, 64'hFFFF_FFFF_8000_0000);

        step("auipc", enc_u(20'h1, 5'd8, 7'b0010111), 64'h1000, 1'b1, 64'h2000, 5'd8, 64'h2000);
        step("addi_x0", enc_i(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM), 64'h0, 1'b0, 64'd5, 5'd0, 64'd0);
        step("slli_bad", enc_i(12'h401, 5'd1, 3'b001, 5'd10, OP_IMM), 64'h0, 1'b0, 64'd0, 5'd10, 64'd1);
        step("store", 32'h00112023, 64'h0, 1'b0, 64'd0, 5'd0, 64'd0);

        // All-zero word marks program end: illegal, halts, writes nothing.
        @(negedge clk);
        inst = 32'h0;
        inst_valid = 1'b1;
        #1;
        chk("halt", {63'b0, halt}, 64'd1);
        chk("halt_illegal", {63'b0, illegal}, 64'd1);
        chk("halt_en", {63'b0, wb_en}, 64'd0);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        #1;
        chk("halt_idle", {63'b0, halt}, 64'd0);
        push("halt_x8", 5'd8, 64'h2000);
        drain();

        // Reset wins over a write issued in the same cycle.
        @(negedge clk);
        reset = 1'b1;
        inst = enc_i(12'd9, 5'd0, 3'b000, 5'd1, OP_IMM);
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        inst_valid = 1'b0;
        push("mid_rst_x1", 5'd1, 64'd0);
        push("mid_rst_x7", 5'd7, 64'd0);
        push("mid_rst_x8", 5'd8, 64'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
